// File: rtl/rec_to_ieee64.sv
`default_nettype none
// ============================================================================
// Module   : rec_to_ieee64
// Purpose  : Converts 65-bit Berkeley recoded binary64 values to IEEE-754
//            binary64 words. It has three pipeline stages with a valid/ready
//            stream on each side. It also produces NaN/Inf/subnormal flags and
//            saturating counters for delivered NaN and Inf results.
// Ports    : clk, reset (async, active-low)
//            in_valid/in_ready/in_rec[64:0]     upstream stream
//            out_valid/out_ready/out_ieee[63:0] downstream stream
//            out_is_nan/out_is_inf/out_is_sub   flags for out_ieee
//            nan_count/inf_count[CNT_W-1:0]     delivered NaN/Inf counts
// Revision : 1.0  initial release
// ============================================================================
module rec_to_ieee64 #(
  parameter int unsigned CANON_NAN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [64:0]      in_rec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_ieee,
  output logic             out_is_nan,
  output logic             out_is_inf,
  output logic             out_is_sub,
  output logic [CNT_W-1:0] nan_count,
  output logic [CNT_W-1:0] inf_count
);

  // Class codes carried from the classify stage to the assemble stage.
  localparam logic [2:0] C_ZERO = 3'd0;
  localparam logic [2:0] C_INF  = 3'd1;
  localparam logic [2:0] C_NAN  = 3'd2;
  localparam logic [2:0] C_NORM = 3'd3;
  localparam logic [2:0] C_SUB  = 3'd4;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic             r_run;        // low until the first edge after reset release
  logic             r_s0_valid;
  logic [64:0]      r_s0_rec;
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [2:0]       r_s1_cls;
  logic [10:0]      r_s1_exp;
  logic [51:0]      r_s1_sig;
  logic [5:0]       r_s1_sh;
  logic             r_s2_valid;
  logic [63:0]      r_s2_ieee;
  logic             r_s2_nan;
  logic             r_s2_inf;
  logic             r_s2_sub;
  logic [CNT_W-1:0] r_nan_cnt;
  logic [CNT_W-1:0] r_inf_cnt;

  // --------------------------------------------------------------------------
  // Handshake chain: each stage moves forward when the next stage is empty
  // or is itself moving. The ready path is combinational all the way back
  // from out_ready, so a full pipeline keeps full throughput.
  // --------------------------------------------------------------------------
  logic w_adv0;
  logic w_adv1;
  logic w_adv2;
  logic w_accept;

  assign w_adv2   = r_s2_valid & out_ready;
  assign w_adv1   = r_s1_valid & (~r_s2_valid | out_ready);
  assign w_adv0   = r_s0_valid & (~r_s1_valid | w_adv1);
  assign in_ready = r_run & (~r_s0_valid | w_adv0);
  assign w_accept = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // S1 classify: decode the recoded exponent from the captured operand
  // --------------------------------------------------------------------------
  logic [11:0] w_e;
  logic [2:0]  w_t;
  logic [11:0] w_sh_full;
  logic [10:0] w_nexp;
  logic [2:0]  w_cls;

  assign w_e       = r_s0_rec[63:52];
  assign w_t       = w_e[11:9];
  assign w_sh_full = 12'h402 - w_e;
  // The low 11 bits of e-0x401 depend only on the low 11 bits of e.
  assign w_nexp    = w_e[10:0] - 11'h401;

  always_comb begin
    w_cls = C_ZERO;
    if (w_t == 3'b000) begin
      w_cls = C_ZERO;
    end else if (w_t == 3'b110) begin
      w_cls = C_INF;
    end else if (w_t == 3'b111) begin
      w_cls = C_NAN;
    end else if (w_e >= 12'h402) begin
      w_cls = C_NORM;
    end else if (w_sh_full <= 12'd52) begin
      w_cls = C_SUB;
    end else begin
      // Exponent too small to be a recoded subnormal: flush to signed zero.
      w_cls = C_ZERO;
    end
  end

  // --------------------------------------------------------------------------
  // S2 assemble: denormalising shift and field packing
  // --------------------------------------------------------------------------
  logic [52:0] w_mant;
  logic [51:0] w_sub_frac;
  logic [63:0] w_ieee;
  logic        w_nan;
  logic        w_inf;
  logic        w_sub;

  assign w_mant     = {1'b1, r_s1_sig};
  assign w_sub_frac = 52'(w_mant >> r_s1_sh);

  always_comb begin
    w_ieee = {r_s1_sign, 63'b0};
    w_nan  = 1'b0;
    w_inf  = 1'b0;
    w_sub  = 1'b0;
    case (r_s1_cls)
      C_INF: begin
        w_ieee = {r_s1_sign, 11'h7FF, 52'b0};
        w_inf  = 1'b1;
      end
      C_NAN: begin
        if (CANON_NAN != 0) begin
          w_ieee = 64'h7FF8_0000_0000_0000;
        end else begin
          w_ieee = {r_s1_sign, 11'h7FF, 1'b1, r_s1_sig[50:0]};
        end
        w_nan = 1'b1;
      end
      C_NORM: begin
        w_ieee = {r_s1_sign, r_s1_exp, r_s1_sig};
      end
      C_SUB: begin
        w_ieee = {r_s1_sign, 11'h000, w_sub_frac};
        w_sub  = 1'b1;
      end
      default: begin
        w_ieee = {r_s1_sign, 63'b0};
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Valid bits and run flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_s0_valid <= 1'b1;
      end else if (w_adv0) begin
        r_s0_valid <= 1'b0;
      end
      if (w_adv0) begin
        r_s1_valid <= 1'b1;
      end else if (w_adv1) begin
        r_s1_valid <= 1'b0;
      end
      if (w_adv1) begin
        r_s2_valid <= 1'b1;
      end else if (w_adv2) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage data: each stage loads only when its input stage advances, so the
  // output holds steady under back-pressure.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s0_rec  <= '0;
      r_s1_sign <= 1'b0;
      r_s1_cls  <= C_ZERO;
      r_s1_exp  <= '0;
      r_s1_sig  <= '0;
      r_s1_sh   <= '0;
      r_s2_ieee <= '0;
      r_s2_nan  <= 1'b0;
      r_s2_inf  <= 1'b0;
      r_s2_sub  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s0_rec <= in_rec;
      end
      if (w_adv0) begin
        r_s1_sign <= r_s0_rec[64];
        r_s1_cls  <= w_cls;
        r_s1_exp  <= w_nexp;
        r_s1_sig  <= r_s0_rec[51:0];
        r_s1_sh   <= w_sh_full[5:0];
      end
      if (w_adv1) begin
        r_s2_ieee <= w_ieee;
        r_s2_nan  <= w_nan;
        r_s2_inf  <= w_inf;
        r_s2_sub  <= w_sub;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event counters, counted on delivery and saturating at all-ones
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nan_cnt <= '0;
      r_inf_cnt <= '0;
    end else begin
      if (w_adv2 && r_s2_nan && (r_nan_cnt != C_CNT_MAX)) begin
        r_nan_cnt <= r_nan_cnt + C_CNT_ONE;
      end
      if (w_adv2 && r_s2_inf && (r_inf_cnt != C_CNT_MAX)) begin
        r_inf_cnt <= r_inf_cnt + C_CNT_ONE;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_ieee   = r_s2_ieee;
  assign out_is_nan = r_s2_nan;
  assign out_is_inf = r_s2_inf;
  assign out_is_sub = r_s2_sub;
  assign nan_count  = r_nan_cnt;
  assign inf_count  = r_inf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rec_to_ieee64.sv
`default_nettype none
// ============================================================================
// Module   : tb_rec_to_ieee64
// Purpose  : Scoreboard bench for rec_to_ieee64. One instance uses canonical
//            NaNs and one keeps the NaN payload. Both share the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_rec_to_ieee64;

  typedef struct packed {
    logic [63:0] canon;
    logic [63:0] raw;
    logic        nan;
    logic        inf;
    logic        sub;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] in_rec;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_ieee;
  logic        out_is_nan;
  logic        out_is_inf;
  logic        out_is_sub;
  logic [15:0] nan_count;
  logic [15:0] inf_count;

  logic        r_in_ready;
  logic        r_out_valid;
  logic [63:0] r_out_ieee;
  logic        r_is_nan;
  logic        r_is_inf;
  logic        r_is_sub;
  logic [15:0] r_nan_count;
  logic [15:0] r_inf_count;

  exp_t        sb[$];
  int          n_vec   = 0;
  int          n_err   = 0;
  int          n_acc   = 0;
  int          n_deliv = 0;
  logic [15:0] m_nan   = 0;
  logic [15:0] m_inf   = 0;
  bit          drv_done;

  rec_to_ieee64 #(.CANON_NAN(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rec(in_rec),
    .out_valid(out_valid), .out_ready(out_ready), .out_ieee(out_ieee),
    .out_is_nan(out_is_nan), .out_is_inf(out_is_inf), .out_is_sub(out_is_sub),
    .nan_count(nan_count), .inf_count(inf_count)
  );

  rec_to_ieee64 #(.CANON_NAN(0), .CNT_W(16)) u_raw (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_rec(in_rec),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_ieee(r_out_ieee),
    .out_is_nan(r_is_nan), .out_is_inf(r_is_inf), .out_is_sub(r_is_sub),
    .nan_count(r_nan_count), .inf_count(r_inf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [64:0] mk(input logic s, input logic [11:0] e, input logic [51:0] f);
    return {s, e, f};
  endfunction

  // Reference conversion, written directly from the format definition.
  function automatic exp_t model(input logic [64:0] r);
    exp_t        x;
    logic        s;
    logic [11:0] e;
    logic [51:0] f;
    logic [52:0] m;
    int          sh;
    s = r[64];
    e = r[63:52];
    f = r[51:0];
    x = '0;
    x.canon = {s, 63'b0};
    if (e[11:9] == 3'b000) begin
      x.canon = {s, 63'b0};
    end else if (e[11:9] == 3'b110) begin
      x.canon = {s, 11'h7FF, 52'b0};
      x.inf   = 1'b1;
    end else if (e[11:9] == 3'b111) begin
      x.canon = 64'h7FF8_0000_0000_0000;
      x.nan   = 1'b1;
    end else if (e >= 12'h402) begin
      x.canon = {s, 11'(e - 12'h401), f};
    end else begin
      sh = 32'h402 - int'(e);
      if (sh <= 52) begin
        m = {1'b1, f};
        for (int i = 0; i < sh; i++) m = m >> 1;
        x.canon = {s, 11'h000, m[51:0]};
        x.sub   = 1'b1;
      end
    end
    x.raw = x.nan ? {s, 11'h7FF, 1'b1, f[50:0]} : x.canon;
    return x;
  endfunction

  // Monitor: push on accept, pop and compare on delivery.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(in_rec));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        check("nan_count", 64'(nan_count), 64'(m_nan));
        check("inf_count", 64'(inf_count), 64'(m_inf));
        if (sb.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'h0);
        end else begin
          e = sb.pop_front();
          check("ieee_canon", out_ieee, e.canon);
          check("ieee_raw", r_out_ieee, e.raw);
          check("flags", 64'({out_is_nan, out_is_inf, out_is_sub}), 64'({e.nan, e.inf, e.sub}));
          if (e.nan && m_nan != 16'hFFFF) m_nan = m_nan + 16'd1;
          if (e.inf && m_inf != 16'hFFFF) m_inf = m_inf + 16'd1;
        end
        n_deliv++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [64:0] r);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_rec   = r;
    n  = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
      if (!ok && n > 400) begin
        check("send_timeout", 64'(ok), 64'h1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'h0);
    repeat (2) tick();
  endtask

  function automatic logic [64:0] rand_rec();
    logic [11:0] e;
    case ($urandom_range(0, 5))
      0:       e = 12'($urandom_range(12'h000, 12'h1FF));
      1:       e = 12'($urandom_range(12'hC00, 12'hDFF));
      2:       e = 12'($urandom_range(12'hE00, 12'hFFF));
      3:       e = 12'($urandom_range(12'h402, 12'hBFF));
      4:       e = 12'($urandom_range(12'h3CE, 12'h401));
      default: e = 12'($urandom_range(12'h200, 12'h3CD));
    endcase
    return mk(1'($urandom), e, {20'($urandom), 32'($urandom)});
  endfunction

  initial begin
    int          a0;
    int          d0;
    int          nc;
    logic [64:0] w5 [5];

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_rec    = '0;
    out_ready = 1'b1;
    drv_done  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_ieee", out_ieee, 64'h0);
    check("rst_flags", 64'({out_is_nan, out_is_inf, out_is_sub}), 64'h0);
    check("rst_counts", 64'({nan_count, inf_count}), 64'h0);
    reset = 1'b1;
    tick();
    check("in_ready_after_rst", 64'(in_ready), 64'h1);

    // Latency of 1.0
    send(mk(1'b0, 12'h800, 52'h0));
    check("lat_c1", 64'(out_valid), 64'h0);
    tick();
    check("lat_c2", 64'(out_valid), 64'h0);
    tick();
    check("lat_c3", 64'(out_valid), 64'h1);
    check("lat_one", out_ieee, 64'h3FF0_0000_0000_0000);
    drain();

    // Directed boundary values, back to back
    send(mk(1'b1, 12'h000, 52'h0));
    send(mk(1'b0, 12'hC00, 52'h0));
    send(mk(1'b0, 12'h401, 52'h0));
    send(mk(1'b0, 12'h3CE, 52'h0));
    send(mk(1'b1, 12'hE00, 52'h1));
    send(mk(1'b0, 12'h402, 52'hABCDE));
    send(mk(1'b1, 12'hBFF, 52'hF_FFFF_FFFF_FFFF));
    send(mk(1'b0, 12'h3CF, 52'h8_0000_0000_0001));
    send(mk(1'b1, 12'h3CD, 52'h1234));
    send(mk(1'b0, 12'h200, 52'h5));
    drain();
    check("inf_count_dir", 64'(inf_count), 64'h1);
    check("nan_count_dir", 64'(nan_count), 64'h1);

    // Random stream under random back-pressure
    fork
      begin
        for (int i = 0; i < 60; i++) send(rand_rec());
        drv_done = 1'b1;
      end
    join_none
    nc = 0;
    while (!drv_done && nc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      nc++;
    end
    check("rand_driver_done", 64'(drv_done), 64'h1);
    drain();

    // Stall: 5 words offered, 3 held, then a full-rate burst
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) w5[i] = mk(1'b0, 12'h800 + 12'(i), 52'(i + 1));
    a0 = n_acc;
    fork
      begin
        for (int i = 0; i < 5; i++) send(w5[i]);
      end
    join_none
    repeat (8) tick();
    check("stall_accepts", 64'(n_acc - a0), 64'h3);
    check("stall_in_ready", 64'(in_ready), 64'h0);
    check("stall_hold_a", out_ieee, model(w5[0]).canon);
    tick();
    check("stall_hold_b", out_ieee, model(w5[0]).canon);
    check("stall_valid", 64'(out_valid), 64'h1);
    d0 = n_deliv;
    out_ready = 1'b1;
    repeat (5) tick();
    check("burst_deliv", 64'(n_deliv - d0), 64'h5);
    repeat (4) tick();
    check("burst_no_extra", 64'(n_deliv - d0), 64'h5);
    drain();

    // Reset with three words in flight
    out_ready = 1'b0;
    fork
      begin
        send(mk(1'b0, 12'hE00, 52'h0));
        send(mk(1'b1, 12'hC00, 52'h0));
        send(mk(1'b0, 12'h800, 52'h0));
      end
    join_none
    repeat (6) tick();
    check("pre_rst_full", 64'(out_valid), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_ieee", out_ieee, 64'h0);
    check("mid_rst_counts", 64'({nan_count, inf_count}), 64'h0);
    sb.delete();
    m_nan = 16'd0;
    m_inf = 16'd0;
    repeat (2) tick();
    reset = 1'b1;
    out_ready = 1'b1;
    d0 = n_deliv;
    repeat (6) tick();
    check("post_rst_no_stale", 64'(n_deliv - d0), 64'h0);
    check("post_rst_valid", 64'(out_valid), 64'h0);

    // NaN counter saturation
    for (int i = 0; i < 65540; i++) send(mk(1'(i), 12'hE00 | 12'(i & 8'hFF), 52'(i)));
    drain();
    check("nan_sat", 64'(nan_count), 64'hFFFF);
    check("inf_after_sat", 64'(inf_count), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
